tft_spi: RTL and testbench
==========================

# tft_spi

Byte-level SPI transmitter for the TFT panel, sitting directly downstream of the drawing blocks (player, maze renderer) that issue `tft_transmit`/`tft_dc`/`tft_data` byte requests and wait on `tft_busy`. It captures one command or data byte per request and shifts it out in SPI mode 0, MSB first. It drives panel chip-select and D/C and reports busy back to the requester. One byte is in flight at a time; there is no buffering.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles. Legal values are 1..255.
- `clk` in 1: system clock; all state changes occur on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tft_transmit` in 1: byte request, level-sensitive. It is sampled only while the block is idle.
- `tft_dc` in 1: D/C for the requested byte (0 = command, 1 = data).
- `tft_data` in 8: byte to send.
- `tft_busy` out 1: combinational, `(state != IDLE) | tft_transmit`.
- `spi_sck` out 1: serial clock. Idles low.
- `spi_mosi` out 1: serial data.
- `spi_cs` out 1: chip select, active-low.
- `spi_dc` out 1: D/C pin to the panel.

## Operation
- States:
  - IDLE: waits for a request.
  - SHIFT: 8 bits; each bit is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
  - HOLD: `CLK_DIV` cycles with SCK low and CS still low.
- IDLE → SHIFT on a clock edge where `tft_transmit`=1. On that edge:
  - latch `tft_data` into an 8-bit shift register;
  - latch `tft_dc` into `spi_dc`;
  - set `spi_cs`=0, `spi_mosi`=`tft_data[7]`, `spi_sck`=0;
  - clear the bit counter and the divider.
- SHIFT:
  - The divider counts `clk` cycles modulo `CLK_DIV`.
  - At the end of the low phase, `spi_sck` goes to 1.
  - At the end of the high phase, `spi_sck` goes to 0, the shift register shifts left, and `spi_mosi` takes the next bit.
  - After the 8th high phase the block enters HOLD; `spi_mosi` keeps `d[0]`.
- HOLD → IDLE after `CLK_DIV` cycles. On that edge `spi_cs`=1.
- Input sampling:
  - `tft_data` and `tft_dc` are sampled only at the capture edge. Changes during SHIFT/HOLD have no effect.
  - `tft_transmit` is ignored outside IDLE.
- Busy handshake:
  - `tft_busy` rises in the same cycle the requester raises `tft_transmit`. A registered requester therefore sees busy at the capture edge, drops `tft_transmit`, and cannot overwrite `tft_data` before capture.
  - Busy stays high until the cycle after the return to IDLE, provided the requester has dropped `tft_transmit`.
- `spi_dc` keeps the last captured value between bytes.
- `spi_mosi` holds its last value in IDLE.
- Mode 0 is required: MOSI is stable for `CLK_DIV` cycles before and after every SCK rising edge.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE;
  - `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `spi_dc`=0;
  - shift register, bit counter and divider = 0.
- Reset mid-byte aborts immediately: CS goes high within the same cycle and no partial-byte recovery is attempted. The first capture after release happens at the first edge with `rst`=1 and `tft_transmit`=1.
- With capture at edge k and D = `CLK_DIV`:
  - SCK rises at k+D, k+3D, …, k+15D.
  - SCK falls at k+2D, …, k+16D.
  - `spi_mosi` changes at k, k+2D, …, k+14D.
  - HOLD spans k+16D to k+17D.
  - State returns to IDLE with `spi_cs`=1 at k+17D.
- Registered busy is high for exactly 17·D cycles per byte.
- Back-to-back requests: the earliest next capture is edge k+17D+1. CS is therefore high for at least one `clk` cycle between bytes.
- Throughput: one byte per 17·D+1 cycles maximum (35 cycles at D=2).
- With D=1, SCK runs at clk/2 and the per-byte cost is 18 cycles.

## Test plan
- Reset state: hold `rst`=0, then release → `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `spi_dc`=0, `tft_busy`=0. No SCK edges occur while idle.
- Single command byte, D=2: request `dc`=0, `data`=8'h2A →
  - exactly 8 SCK rising edges, at capture +2, +6, …, +30;
  - MOSI sampled on the rising edges reads 0,0,1,0,1,0,1,0;
  - `spi_dc`=0 throughout;
  - CS high at capture +34.
- Data stream via a player-style requester: bytes 8'h00, 8'h01, 8'h02 with `dc`=1 →
  - each byte is captured once, none duplicated or skipped;
  - CS high ≥1 cycle between bytes;
  - `spi_dc`=1;
  - decoded bytes match in order.
- Input stability: capture 8'hA5, then drive `tft_data`=8'h5A and toggle `tft_dc` during SHIFT → decoded byte is 8'hA5 and `spi_dc` is unchanged.
- Reset mid-byte: assert `rst`=0 after the 3rd SCK rise of 8'hFF →
  - CS=1 and SCK=0 immediately;
  - after release, the next byte 8'h2C is shifted complete and correct.
- `CLK_DIV`=1: send 8'h81 → SCK high/low phases of 1 cycle, MOSI pattern 1,0,0,0,0,0,0,1, busy for 17 cycles.

Source files
------------

// File: rtl/tft_spi.sv
// Byte-level SPI mode-0 transmitter for the TFT panel: captures one command/data
// byte per request and shifts it out MSB first with chip-select and D/C.
module tft_spi #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tft_transmit,
   input  logic       tft_dc,
   input  logic [7:0] tft_data,
   output logic       tft_busy,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_cs,
   output logic       spi_dc
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t     state, state_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] div, div_nxt;
   logic       sck_nxt, cs_nxt, dc_nxt;
   logic       phase_end;

   assign phase_end = (div == DIV_LAST);
   // MOSI is the shift register MSB; the last fall skips the shift so d[0] is held.
   assign spi_mosi  = shreg[7];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         shreg   <= 8'd0;
         bit_cnt <= 3'd0;
         div     <= 8'd0;
         spi_sck <= 1'b0;
         spi_cs  <= 1'b1;
         spi_dc  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         div     <= div_nxt;
         spi_sck <= sck_nxt;
         spi_cs  <= cs_nxt;
         spi_dc  <= dc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tft_transmit) state_nxt = SHIFT;
         SHIFT:   if (phase_end && spi_sck && (bit_cnt == 3'd7)) state_nxt = HOLD;
         HOLD:    if (phase_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tft_busy    = (state != IDLE) | tft_transmit;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      div_nxt     = div;
      sck_nxt     = spi_sck;
      cs_nxt      = spi_cs;
      dc_nxt      = spi_dc;
      case (state)
         IDLE: begin
            if (tft_transmit) begin
               shreg_nxt   = tft_data;
               dc_nxt      = tft_dc;
               cs_nxt      = 1'b0;
               sck_nxt     = 1'b0;
               bit_cnt_nxt = 3'd0;
               div_nxt     = 8'd0;
            end
         end
         SHIFT: begin
            if (phase_end) begin
               div_nxt = 8'd0;
               if (!spi_sck) begin
                  sck_nxt = 1'b1;
               end else begin
                  sck_nxt     = 1'b0;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt != 3'd7) shreg_nxt = {shreg[6:0], 1'b0};
               end
            end else begin
               div_nxt = div + 8'd1;
            end
         end
         HOLD: begin
            if (phase_end) begin
               div_nxt = 8'd0;
               cs_nxt  = 1'b1;
            end else begin
               div_nxt = div + 8'd1;
            end
         end
         default: begin
            cs_nxt  = 1'b1;
            sck_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tft_spi.sv
// Directed bench for tft_spi: one instance at CLK_DIV=2, one at CLK_DIV=1.
module tb_tft_spi;

   logic       clk = 1'b0;
   logic       rst;
   logic       tr0, tr1, dc_in, sel;
   logic [7:0] data_in;
   logic       busy0, sck0, mosi0, cs0, dc0;
   logic       busy1, sck1, mosi1, cs1, dc1;
   logic       busy_m, sck_m, mosi_m, cs_m, dc_m;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   tft_spi #(.CLK_DIV(2)) dut (
      .clk(clk), .rst(rst), .tft_transmit(tr0), .tft_dc(dc_in), .tft_data(data_in),
      .tft_busy(busy0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_cs(cs0), .spi_dc(dc0)
   );

   tft_spi #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .tft_transmit(tr1), .tft_dc(dc_in), .tft_data(data_in),
      .tft_busy(busy1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_cs(cs1), .spi_dc(dc1)
   );

   assign busy_m = sel ? busy1 : busy0;
   assign sck_m  = sel ? sck1  : sck0;
   assign mosi_m = sel ? mosi1 : mosi0;
   assign cs_m   = sel ? cs1   : cs0;
   assign dc_m   = sel ? dc1   : dc0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [7:0] data, input logic dc, input int d,
                       input bit perturb, input int abort_rise);
      logic [7:0] got = 8'd0;
      int nrise = 0, cs_at = -1, busy_cnt = 0, dc_bad = 0, mode_bad = 0;
      logic prev_sck, prev_mosi, rose, fell;
      if (sel) tr1 = 1'b1; else tr0 = 1'b1;
      data_in = data;
      dc_in   = dc;
      #1;
      chk("busy_comb", busy_m, 1);
      tick();
      tr0 = 1'b0;
      tr1 = 1'b0;
      #1;
      chk("cap_cs", cs_m, 0);
      chk("cap_sck", sck_m, 0);
      chk("cap_mosi", mosi_m, data[7]);
      chk("cap_dc", dc_m, dc);
      if (busy_m) busy_cnt++;
      prev_sck  = sck_m;
      prev_mosi = mosi_m;
      for (int n = 1; n <= 20 * d + 4; n++) begin
         tick();
         if (busy_m) busy_cnt++;
         if (dc_m !== dc) dc_bad++;
         rose = sck_m && !prev_sck;
         fell = !sck_m && prev_sck;
         if (mosi_m !== prev_mosi && !fell) mode_bad++;
         if (rose) begin
            chk($sformatf("rise%0d_time", nrise), n, (2 * nrise + 1) * d);
            got = {got[6:0], mosi_m};
            nrise++;
         end
         if (perturb && n == 3) begin
            data_in = 8'h5A;
            dc_in   = ~dc_in;
         end
         if (abort_rise != 0 && rose && nrise == abort_rise) begin
            rst = 1'b0;
            #1;
            chk("abort_cs", cs_m, 1);
            chk("abort_sck", sck_m, 0);
            chk("abort_busy", busy_m, 0);
            return;
         end
         if (cs_m) begin
            cs_at = n;
            break;
         end
         prev_sck  = sck_m;
         prev_mosi = mosi_m;
      end
      chk("nrise", nrise, 8);
      chk("byte", got, data);
      chk("cs_high_at", cs_at, 17 * d);
      chk("busy_cycles", busy_cnt, 17 * d);
      chk("dc_stable", dc_bad, 0);
      chk("mosi_mode0", mode_bad, 0);
      chk("busy_done", busy_m, 0);
   endtask

   initial begin
      int idle_sck;
      rst     = 1'b0;
      tr0     = 1'b0;
      tr1     = 1'b0;
      dc_in   = 1'b0;
      data_in = 8'h00;
      sel     = 1'b0;
      repeat (3) tick();
      chk("rst_cs", cs0, 1);
      chk("rst_sck", sck0, 0);
      chk("rst_mosi", mosi0, 0);
      chk("rst_dc", dc0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_cs1", cs1, 1);
      rst = 1'b1;
      idle_sck = 0;
      repeat (10) begin
         tick();
         if (sck0 || sck1 || !cs0 || !cs1) idle_sck++;
      end
      chk("idle_quiet", idle_sck, 0);

      xfer(8'h2A, 1'b0, 2, 0, 0);

      xfer(8'h00, 1'b1, 2, 0, 0);
      xfer(8'h01, 1'b1, 2, 0, 0);
      xfer(8'h02, 1'b1, 2, 0, 0);
      idle_sck = 0;
      repeat (20) begin
         tick();
         if (sck0 || !cs0) idle_sck++;
      end
      chk("stream_no_dup", idle_sck, 0);
      chk("dc_hold", dc0, 1);

      xfer(8'hA5, 1'b0, 2, 1, 0);

      xfer(8'hFF, 1'b1, 2, 0, 3);
      tick();
      tick();
      rst = 1'b1;
      xfer(8'h2C, 1'b0, 2, 0, 0);

      sel = 1'b1;
      xfer(8'h81, 1'b0, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
